// File: rtl/hazard_free_rr_arbiter_pkg.sv
// Shared types and helpers for the hazard-free round-robin arbiter.
// Contents: FSM state enum, requester-count ceiling, rr_pick (rotating
// priority search) and onehot encode.
package hazard_arb_pkg;

  localparam int unsigned ARB_N_MAX = 8;
  localparam int unsigned ARB_PTR_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [ARB_PTR_W-1:0] idx;
  } pick_t;

  // First set bit of req searching ptr, ptr+1, ... wrapping at n.
  function automatic pick_t rr_pick(input logic [ARB_N_MAX-1:0] req,
                                    input logic [ARB_PTR_W-1:0] ptr,
                                    input int unsigned          n);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < ARB_N_MAX; i++) begin
      if (i < n) begin
        j = 32'(ptr) + i;
        if (j >= n) j = j - n;
        if (!r.valid && req[ARB_PTR_W'(j)]) begin
          r.valid = 1'b1;
          r.idx   = ARB_PTR_W'(j);
        end
      end
    end
    return r;
  endfunction

  function automatic logic [ARB_N_MAX-1:0] onehot(input logic [ARB_PTR_W-1:0] idx);
    logic [ARB_N_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hazard_free_rr_arbiter_if.sv
// Requester/arbiter bundle.
// master: requester side (drives req); slave: arbiter side (drives gnt,
// gnt_id, busy, preempt).
interface hazard_free_rr_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           preempt;

  modport master (output req, input gnt, gnt_id, busy, preempt);
  modport slave  (input req, output gnt, gnt_id, busy, preempt);
endinterface

// File: rtl/hazard_free_rr_arbiter_req_sample_reg.sv
// req_sample_reg: W-bit capture register for glitchy or loosely timed inputs.
// Ports: clk, rst (async, active-high), d (raw input), q (registered copy).
module req_sample_reg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/hazard_free_rr_arbiter.sv
// hazard_free_rr_arbiter: round-robin arbiter whose grants come straight from
// flops, with a forced all-zero gap between owners (break-before-make).
// Ports: clk, rst (async, active-high), bus (slave modport: req in;
// gnt, gnt_id, busy, preempt out, all registered).
// Build option: ARB_TIMEOUT_EN enables hold-time preemption after HOLD_MAX
// grant cycles when another requester is waiting; otherwise preempt is 0.
module hazard_free_rr_arbiter
  import hazard_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned IDW      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  hazard_free_rr_arbiter_if.slave  bus
);

  // Elaboration-time parameter sanity
  if (N < 2 || N > ARB_N_MAX)          $error("N out of range");
  if (IDW != $clog2(N))                $error("IDW must be ceil(log2(N))");
  if (HOLD_MAX < 1 || HOLD_MAX > 255)  $error("HOLD_MAX out of range");

  logic [N-1:0]   req_r;
  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           busy_q, busy_d;
  logic           preempt_q, preempt_d;
  logic [IDW-1:0] ptr_after;
  pick_t          pick;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HCW = $clog2(HOLD_MAX + 1);
  logic [HCW-1:0] hold_q, hold_d;
`endif

  // Only registered requests reach the decision logic
  req_sample_reg #(.W(N)) u_req_sample (
    .clk (clk),
    .rst (rst),
    .d   (bus.req),
    .q   (req_r)
  );

  assign pick      = rr_pick(ARB_N_MAX'(req_r), ARB_PTR_W'(ptr_q), N);
  // Pointer moves to the requester after the releasing owner, wrapping at N
  assign ptr_after = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif

    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick.valid) begin
          gnt_d    = N'(onehot(pick.idx));
          gnt_id_d = IDW'(pick.idx);
          busy_d   = 1'b1;
          state_d  = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d   = HCW'(1);
`endif
        end
      end

      GRANT: begin
        if (!req_r[gnt_id_q]) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_after;
          state_d = RELEASE;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_q == HCW'(HOLD_MAX) && (req_r & ~gnt_q) != '0) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          preempt_d = 1'b1;
          ptr_d     = ptr_after;
          state_d   = RELEASE;
        end else begin
          if (hold_q != HCW'(HOLD_MAX)) hold_d = hold_q + HCW'(1);
`endif
        end
      end

      RELEASE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

endmodule
